// File: rtl/sha1_pkg.sv
// Shared constants and the fetch FSM state type for the SHA-1 block fetch path.
package sha1_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned BLOCK_IDX_W     = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned BYTES_PER_WORD  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } fetch_state_e;

endpackage

// File: rtl/sha1_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a pop frees a slot for a push in the same cycle.
module sha1_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  push_while_full: assert property (@(posedge clk) disable iff (rst_i)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/sha1_block_fetch_master.sv
// Avalon-MM read master fetching N 16-word message blocks and streaming them with sop/eop framing.
module sha1_block_fetch_master
  import sha1_pkg::*;
#(
  parameter int unsigned ADDR_W          = 15,
  parameter int unsigned CNT_W           = 9,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_blocks,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);
  localparam int unsigned TOT_W  = CNT_W + BLOCK_IDX_W;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e           state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [TOT_W-1:0]       issue_left_q, issue_left_d;
  logic [TOT_W-1:0]       pop_left_q, pop_left_d;
  logic [OUT_W-1:0]       outst_q, outst_d;
  logic [BLOCK_IDX_W-1:0] idx_q, idx_d;
  logic [FCNT_W-1:0]      fifo_count;
  logic                   fifo_empty, fifo_full;
  logic                   credit_ok, accept, ret, pop, launch;
  logic [TOT_W-1:0]       total_words;

  assign total_words = {num_blocks, {BLOCK_IDX_W{1'b0}}};
  assign launch      = (state_q == ST_IDLE) && start;
  assign accept      = avm_read && !avm_waitrequest;
  // Late responses after an abort land in IDLE and must not reach the FIFO.
  assign ret         = avm_readdatavalid && (state_q != ST_IDLE);
  assign pop         = st_valid && st_ready;

  // Pushes during a stall move a word from outstanding to the FIFO, so the check cannot drop mid-wait.
  assign credit_ok = (32'(outst_q) + 32'(fifo_count) + 32'd1 <= FIFO_DEPTH)
                  && (32'(outst_q) < MAX_OUTSTANDING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      outst_q      <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      outst_q      <= outst_d;
      idx_q        <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (num_blocks == '0) ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:  if (accept && issue_left_q == TOT_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN:  if (pop && pop_left_q == TOT_W'(1)) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    avm_read = 1'b0;
    case (state_q)
      ST_ISSUE:  begin busy = 1'b1; avm_read = credit_ok; end
      ST_DRAIN:  busy = 1'b1;
      ST_FINISH: begin busy = 1'b1; done = 1'b1; end
      default:   ;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    outst_d      = outst_q;
    idx_d        = idx_q;
    if (launch) begin
      addr_d       = {base_addr[ADDR_W-1:2], 2'b00};
      issue_left_d = total_words;
      pop_left_d   = total_words;
      idx_d        = '0;
    end
    if (accept) begin
      addr_d       = addr_q + ADDR_W'(BYTES_PER_WORD);
      issue_left_d = issue_left_q - 1'b1;
    end
    if (accept && !ret)                        outst_d = outst_q + 1'b1;
    else if (!accept && ret && outst_q != '0)  outst_d = outst_q - 1'b1;
    if (pop) begin
      pop_left_d = pop_left_q - 1'b1;
      idx_d      = idx_q + 1'b1;
    end
  end

  sha1_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (reset),
    .push_i  (ret),
    .data_i  (avm_readdata),
    .pop_i   (pop),
    .data_o  (st_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign st_valid       = !fifo_empty;
  assign st_sop         = st_valid && (idx_q == '0);
  assign st_eop         = st_valid && (idx_q == '1);

endmodule

// File: tb/tb_sha1_block_fetch_master.sv
// Randomised bench: behavioural memory slave plus an address/word-stream model of the fetch master.
module tb_sha1_block_fetch_master;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned CNT_W      = 9;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned MAX_OUT    = 4;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_blocks;
  logic              busy, done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       st_data;
  logic              st_valid, st_ready, st_sop, st_eop;

  sha1_block_fetch_master #(
    .ADDR_W          (ADDR_W),
    .CNT_W           (CNT_W),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .num_blocks        (num_blocks),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_sop            (st_sop),
    .st_eop            (st_eop)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0, failures = 0, cyc = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  logic [ADDR_W-1:0] resp_addr_q[$];
  int unsigned       resp_due_q[$];
  bit                resp_live_q[$];

  int  outst_m = 0, buf_m = 0, returned_m = 0;
  int  txn_reads = 0, pops = 0, done_cnt = 0, wait_cycles = 0, late_dropped = 0;
  int  ready_hold = 0, stall_at = -1, stall_left = 0;
  int unsigned lat_min = 0, lat_max = 0, start_cyc = 0, last_due = 0;
  bit  rdy_rand = 0, wr_rand = 0, cur_live = 0, prev_wait = 0, prev_done = 0;
  bit  first_read_pending = 0, zero_txn = 0;
  logic [ADDR_W-1:0] prev_addr = '0;

  function automatic logic [31:0] memval(input logic [ADDR_W-1:0] a);
    return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic observe();
    int o_now;
    int b_now;
    int unsigned due;
    o_now = outst_m;
    b_now = buf_m;
    check("byteenable", 32'(avm_byteenable), 32'hF);
    check("st_valid", 32'(st_valid), 32'(b_now != 0));
    if (prev_wait) begin
      check("hold_read", 32'(avm_read), 32'd1);
      check("hold_addr", 32'(avm_address), 32'(prev_addr));
    end
    prev_wait = avm_read && avm_waitrequest;
    prev_addr = avm_address;
    if (avm_read) begin
      check("credit", 32'((o_now + b_now + 1 <= int'(FIFO_DEPTH)) && (o_now < int'(MAX_OUT))), 32'd1);
      if (first_read_pending) begin
        check("start_lat", cyc - start_cyc, 32'd1);
        first_read_pending = 0;
      end
      if (avm_waitrequest) wait_cycles++;
    end
    if (avm_read && !avm_waitrequest) begin
      if (exp_addr_q.size() == 0) check("extra_read", 32'(avm_address), 32'hFFFF_FFFF);
      else check("rd_addr", 32'(avm_address), 32'(exp_addr_q.pop_front()));
      txn_reads++;
      outst_m++;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due < last_due) due = last_due;
      last_due = due;
      resp_addr_q.push_back(avm_address);
      resp_due_q.push_back(due);
      resp_live_q.push_back(1'b1);
    end
    if (avm_readdatavalid && cur_live) begin
      outst_m--;
      buf_m++;
      returned_m++;
    end
    if (st_valid && st_ready) begin
      if (exp_data_q.size() == 0) check("extra_word", st_data, 32'hDEAD_BEEF);
      else begin
        check("st_data", st_data, exp_data_q.pop_front());
        check("st_sop", 32'(st_sop), 32'(pops % 16 == 0));
        check("st_eop", 32'(st_eop), 32'(pops % 16 == 15));
      end
      pops++;
      buf_m--;
    end
    if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
    prev_done = done;
    if (done) begin
      done_cnt++;
      check("busy_at_done", 32'(busy), 32'd1);
      check("all_popped", exp_data_q.size(), 32'd0);
      if (zero_txn) check("zero_done_lat", cyc - start_cyc, 32'd1);
    end
  endtask

  task automatic drive();
    start = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = $urandom;
    cur_live = 1'b0;
    if (resp_addr_q.size() != 0 && resp_due_q[0] <= cyc) begin
      avm_readdata = memval(resp_addr_q.pop_front());
      void'(resp_due_q.pop_front());
      cur_live = resp_live_q.pop_front();
      if (!cur_live) late_dropped++;
      avm_readdatavalid = 1'b1;
    end
    if (stall_left > 0 && avm_read && txn_reads == stall_at) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avm_waitrequest = wr_rand && ($urandom_range(3, 0) == 0);
    end
    if (ready_hold > 0) begin
      st_ready = 1'b0;
      ready_hold--;
    end else begin
      st_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (!reset) observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic start_fetch(input logic [ADDR_W-1:0] base, input int nb, input int hold,
                             input bit rr, input bit wr, input int st_at,
                             input int unsigned lmin, input int unsigned lmax);
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] a;
    exp_addr_q.delete();
    exp_data_q.delete();
    b = base & ~ADDR_W'(3);
    for (int i = 0; i < nb * 16; i++) begin
      a = b + ADDR_W'(4 * i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(memval(a));
    end
    txn_reads = 0; pops = 0; done_cnt = 0; wait_cycles = 0; returned_m = 0;
    ready_hold = hold; rdy_rand = rr; wr_rand = wr;
    stall_at = st_at; stall_left = (st_at >= 0) ? 5 : 0;
    lat_min = lmin; lat_max = lmax;
    zero_txn = (nb == 0);
    first_read_pending = (nb != 0);
    base_addr = base;
    num_blocks = CNT_W'(nb);
    start = 1'b1;
    start_cyc = cyc + 1;
    step();
  endtask

  task automatic finish_fetch(input int nb);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) step();
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    repeat (3) step();
    check("done_count", done_cnt, 32'd1);
    check("read_count", txn_reads, 32'(nb * 16));
    check("word_count", pops, 32'(nb * 16));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_fetch(input logic [ADDR_W-1:0] base, input int nb, input bit rr,
                           input bit wr, input int unsigned lmax);
    start_fetch(base, nb, 0, rr, wr, -1, 0, lmax);
    finish_fetch(nb);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_blocks = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; st_ready = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_valid", 32'(st_valid), 32'd0);
    check("rst_sop", 32'(st_sop), 32'd0);
    check("rst_eop", 32'(st_eop), 32'd0);
    reset = 1'b0;
    step();

    // single block, clean bus
    run_fetch(15'h0040, 1, 0, 0, 0);

    // downstream blocked: buffer fills to FIFO_DEPTH and issue stops
    start_fetch(15'h0100, 3, 60, 0, 0, -1, 0, 2);
    while (ready_hold > 0) step();
    check("hold_reads", txn_reads, FIFO_DEPTH);
    check("hold_buffered", buf_m, FIFO_DEPTH);
    check("hold_valid", 32'(st_valid), 32'd1);
    finish_fetch(3);

    // five-cycle waitrequest on the third read
    start_fetch(15'h0200, 1, 0, 0, 0, 2, 0, 1);
    finish_fetch(1);
    check("stall_cycles", wait_cycles, 32'd5);

    // address wrap
    run_fetch(15'h7FF8, 1, 0, 0, 0);

    // zero blocks, then a start while busy
    start_fetch(15'h0300, 0, 0, 0, 0, -1, 0, 0);
    num_blocks = CNT_W'(1);
    start = 1'b1;
    repeat (6) step();
    check("zero_done_count", done_cnt, 32'd1);
    check("zero_reads", txn_reads, 32'd0);

    // abort mid-transfer
    start_fetch(15'h0400, 2, 0, 0, 0, -1, 2, 2);
    begin
      int n = 0;
      while (!(returned_m >= 7 && outst_m >= 2) && n < 300) begin step(); n++; end
      check("abort_reached", 32'(n < 300), 32'd1);
    end
    foreach (resp_live_q[k]) resp_live_q[k] = 1'b0;
    cur_live = 1'b0;
    reset = 1'b1;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_read", 32'(avm_read), 32'd0);
    check("abort_addr", 32'(avm_address), 32'd0);
    check("abort_valid", 32'(st_valid), 32'd0);
    check("abort_sop", 32'(st_sop), 32'd0);
    check("abort_eop", 32'(st_eop), 32'd0);
    reset = 1'b0;
    outst_m = 0; buf_m = 0; prev_wait = 0; prev_done = 0; first_read_pending = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (8) step();
    check("late_dropped", 32'(late_dropped >= 1), 32'd1);
    run_fetch(15'h0A00, 1, 0, 0, 1);

    // randomised traffic, including unaligned bases
    for (int t = 0; t < 5; t++) begin
      run_fetch(15'($urandom), 1 + int'($urandom_range(2, 0)), 1, 1, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
